// File: rtl/riscv_writeback_arbiter.sv
// rtl/riscv_writeback_arbiter.sv - register file write-port arbiter for ALU results and load responses
module riscv_writeback_arbiter #(
  parameter int LD_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        regWrite,
  output logic [31:0] busy,
  output logic        issue_err
);

  localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_entry_t;

  // Extension happens before buffering so the FIFO holds final register values.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*lo +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  ld_entry_t              fifo_mem [LD_FIFO_DEPTH];
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [4:0]             write_reg_q, write_reg_d;
  logic [31:0]            write_data_q, write_data_d;
  logic                   reg_write_q, reg_write_d;
  logic [31:0]            busy_q, busy_d;
  logic                   issue_err_q, issue_err_d;

  logic                   push;
  logic                   pop;
  ld_entry_t              head;
  ld_entry_t              push_entry;
  logic [31:0]            clr_mask;
  logic [31:0]            set_mask;

  // Ready depends only on the registered count; a pop this cycle does not free a slot early.
  assign ld_ready   = (count_q < CNT_W'(LD_FIFO_DEPTH));
  assign push       = ld_valid & ld_ready;
  // Pop is decided on the pre-push count, so a fresh entry can never leave in its push cycle.
  assign pop        = ~alu_valid & (count_q != '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign push_entry = '{rd: ld_rd, data: extract_load(ld_data, ld_funct3, ld_addr_lo)};

  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign regWrite  = reg_write_q;
  assign busy      = busy_q;
  assign issue_err = issue_err_q;

  // Next-state: FIFO bookkeeping, port arbitration (ALU first) and the load scoreboard.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    clr_mask     = '0;
    set_mask     = '0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (alu_valid) begin
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
      reg_write_d  = (alu_rd != 5'd0);
    end else if (pop) begin
      write_reg_d  = head.rd;
      write_data_d = head.data;
      reg_write_d  = (head.rd != 5'd0);
      if (head.rd != 5'd0) clr_mask[head.rd] = 1'b1;
    end

    if (ld_issue && (ld_issue_rd != 5'd0)) set_mask[ld_issue_rd] = 1'b1;

    // Set after clear so a same-edge re-issue keeps the register busy.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;

    issue_err_d = issue_err_q |
                  (ld_issue && (ld_issue_rd != 5'd0) && busy_q[ld_issue_rd] && !clr_mask[ld_issue_rd]);
  end

  // State registers; reset discards buffered responses by clearing the count and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      busy_q       <= '0;
      issue_err_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
      busy_q       <= busy_d;
      issue_err_q  <= issue_err_d;
    end
  end

  // Response storage; contents are only meaningful below the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_riscv_writeback_arbiter.sv
// tb/tb_riscv_writeback_arbiter.sv - randomized and directed bench for riscv_writeback_arbiter
module tb_riscv_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] busy;
  logic        issue_err;

  always #5 clk = ~clk;

  riscv_writeback_arbiter #(.LD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .busy(busy), .issue_err(issue_err)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        mq[$];
  logic [31:0] mbusy;
  logic        merr;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic        e_we;
  bit          last_accept;

  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] v;
    int          bsh;
    int          hsh;
    bsh = 8 * int'(lo);
    hsh = lo[1] ? 16 : 0;
    case (f3)
      3'b000: begin v = (w >> bsh) & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'b001: begin v = (w >> hsh) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b100: v = (w >> bsh) & 32'hFF;
      3'b101: v = (w >> hsh) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy  = '0;
    merr   = 1'b0;
    e_reg  = '0;
    e_data = '0;
    e_we   = 1'b0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_funct3 = 0; ld_addr_lo = 0;
  endtask

  // One clock: check ready, advance the model with the current inputs, clock, compare outputs.
  task automatic step();
    bit   pre_ready;
    bit   clr;
    logic [4:0] clr_rd;
    ent_t e;
    pre_ready = (mq.size() < DEPTH);
    check("ld_ready", 32'(ld_ready), 32'(pre_ready));
    clr    = 0;
    clr_rd = '0;
    if (alu_valid) begin
      e_reg = alu_rd; e_data = alu_data; e_we = (alu_rd != 0);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      e_reg = e.rd; e_data = e.data; e_we = (e.rd != 0);
      if (e.rd != 0) begin clr = 1; clr_rd = e.rd; mbusy[e.rd] = 1'b0; end
    end else begin
      e_we = 1'b0;
    end
    if (ld_issue && ld_issue_rd != 0) begin
      if (mbusy[ld_issue_rd] && !(clr && clr_rd == ld_issue_rd)) merr = 1'b1;
      mbusy[ld_issue_rd] = 1'b1;
    end
    last_accept = ld_valid && pre_ready;
    if (last_accept) mq.push_back('{rd: ld_rd, data: ref_ext(ld_data, ld_funct3, ld_addr_lo)});
    @(posedge clk);
    #1;
    check("regWrite",  32'(regWrite),  32'(e_we));
    check("writeReg",  32'(writeReg),  32'(e_reg));
    check("writeData", writeData,      e_data);
    check("busy",      busy,           mbusy);
    check("issue_err", 32'(issue_err), 32'(merr));
  endtask

  task automatic mid_cycle_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_regWrite",  32'(regWrite),  32'd0);
    check("rst_writeReg",  32'(writeReg),  32'd0);
    check("rst_writeData", writeData,      32'd0);
    check("rst_busy",      busy,           32'd0);
    check("rst_issue_err", 32'(issue_err), 32'd0);
    check("rst_ld_ready",  32'(ld_ready),  32'd1);
    model_reset();
    idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] exp;
  } ext_case_t;

  initial begin
    ext_case_t   ext_cases[5];
    logic [4:0]  orq[$];
    bit          hold;

    ext_cases[0] = '{f3: 3'b000, lo: 2'd3, exp: 32'hFFFF_FF80};
    ext_cases[1] = '{f3: 3'b100, lo: 2'd1, exp: 32'h0000_007F};
    ext_cases[2] = '{f3: 3'b001, lo: 2'd2, exp: 32'hFFFF_80FF};
    ext_cases[3] = '{f3: 3'b101, lo: 2'd0, exp: 32'h0000_7F01};
    ext_cases[4] = '{f3: 3'b010, lo: 2'd0, exp: 32'h80FF_7F01};

    reset_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("init_regWrite", 32'(regWrite), 32'd0);
    check("init_busy",     busy,          32'd0);
    check("init_ld_ready", 32'(ld_ready), 32'd1);

    // ALU path
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    check("alu_we",   32'(regWrite), 32'd1);
    check("alu_rd",   32'(writeReg), 32'd5);
    check("alu_data", writeData,     32'hDEAD_BEEF);
    alu_rd = 5'd0; alu_data = 32'h1234_5678;
    step();
    check("alu_x0_we", 32'(regWrite), 32'd0);
    check("alu_x0_rd", 32'(writeReg), 32'd0);
    idle();
    step();

    // Load extraction, two-cycle latency
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1; ld_rd = 5'd10; ld_data = 32'h80FF_7F01;
      ld_funct3 = ext_cases[i].f3; ld_addr_lo = ext_cases[i].lo;
      step();
      check("ext_lat1_we", 32'(regWrite), 32'd0);
      idle();
      step();
      check("ext_we",   32'(regWrite), 32'd1);
      check("ext_data", writeData,     ext_cases[i].exp);
    end

    // Contention: ALU holds the port while three loads arrive
    for (int i = 0; i < 8; i++) begin
      alu_valid = (i < 4); alu_rd = 5'd1; alu_data = 32'(i);
      if (i == 0) begin ld_valid = 1; ld_rd = 5'd11; ld_data = 32'hA; ld_funct3 = 3'b010; end
      if (i == 1) begin ld_rd = 5'd12; ld_data = 32'hB; end
      if (i == 2) begin
        ld_rd = 5'd13; ld_data = 32'hC;
        check("cont_full", 32'(ld_ready), 32'd0);
      end
      if (i == 6) ld_valid = 0;
      step();
      if (i == 3) check("cont_held", 32'(ld_ready), 32'd0);
      if (i == 4) check("cont_ord0", 32'(writeReg), 32'd11);
      if (i == 5) check("cont_ord1", 32'(writeReg), 32'd12);
      if (i == 6) begin
        check("cont_ord2", 32'(writeReg), 32'd13);
        check("cont_dat2", writeData,     32'hC);
      end
      if (i == 5) ld_valid = 0;
    end
    idle();

    // Scoreboard
    ld_issue = 1; ld_issue_rd = 5'd7;
    step();
    check("sb_set", 32'(busy[7]), 32'd1);
    idle();
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h77; ld_funct3 = 3'b010;
    step();
    idle();
    ld_issue = 1; ld_issue_rd = 5'd7;
    step();
    check("sb_reissue_busy", 32'(busy[7]),   32'd1);
    check("sb_reissue_err",  32'(issue_err), 32'd0);
    check("sb_reissue_we",   32'(regWrite),  32'd1);
    idle();
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h78; ld_funct3 = 3'b010;
    step();
    idle();
    step();
    check("sb_clear", 32'(busy[7]), 32'd0);
    ld_issue = 1; ld_issue_rd = 5'd9;
    step();
    step();
    check("sb_err", 32'(issue_err), 32'd1);
    idle();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h3;
    ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99; ld_funct3 = 3'b010;
    step();
    check("sb_err_sticky", 32'(issue_err), 32'd1);

    // Reset mid-operation with a buffered response
    mid_cycle_reset();
    step();
    check("post_rst_we", 32'(regWrite), 32'd0);

    // Randomized mix
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_rd    = 5'($urandom);
      alu_data  = $urandom;
      ld_issue  = ($urandom_range(0, 9) < 3);
      ld_issue_rd = 5'($urandom);
      if (ld_issue) orq.push_back(ld_issue_rd);
      if (!hold) begin
        if (orq.size() > 0 && $urandom_range(0, 9) < 6) begin
          ld_valid   = 1;
          ld_rd      = orq.pop_front();
          ld_data    = $urandom;
          ld_funct3  = 3'($urandom);
          ld_addr_lo = 2'($urandom);
        end else begin
          ld_valid = 0;
        end
      end
      step();
      hold = ld_valid && !last_accept;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_writeback_arbiter.md
# riscv_writeback_arbiter

Write-side master for the RV32 integer register file: merges single-cycle ALU results and variable-latency load responses onto the register file's single write port (writeReg/writeData/regWrite). It sign/zero-extends load data, buffers load responses in a small FIFO while the ALU owns the port, and keeps a per-register busy scoreboard for outstanding loads so issue logic can stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- LD_FIFO_DEPTH, 2, load-response buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result valid this cycle; always accepted
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_rd  in  5  destination of the issued load
- ld_valid  in  1  load response valid
- ld_ready  out  1  FIFO can accept a response (= not full)
- ld_rd  in  5  load response destination
- ld_data  in  32  raw aligned memory word
- ld_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- ld_addr_lo  in  2  byte address bits [1:0]
- writeReg  out  5  register file write index
- writeData  out  32  register file write data
- regWrite  out  1  register file write enable
- busy  out  32  per-register outstanding-load bits; busy[0] always 0
- issue_err  out  1  sticky: load issued to an already-busy register

## Operation
- Load extraction at FIFO push: byte = ld_data[8*ld_addr_lo +: 8]; half = ld_data[16*ld_addr_lo[1] +: 16] (ld_addr_lo[0] ignored). LB/LH sign-extend, LBU/LHU zero-extend, LW passes word. funct3 011/110/111 treated as LW.
- Push when ld_valid && ld_ready; ld_ready = (count < LD_FIFO_DEPTH), purely from registered count (no same-cycle pop pass-through).
- Port arbitration each cycle, ALU has strict priority:
  - alu_valid: emit ALU write; FIFO not popped.
  - else FIFO non-empty: pop head and emit it.
  - else regWrite 0.
- Simultaneous push and pop: count unchanged; a pushed entry never pops in its push cycle.
- Writes to x0 (from either source) are consumed but emit regWrite=0; writeReg/writeData still update.
- Scoreboard: ld_issue with rd≠0 sets busy[rd] at the edge; emitted load write clears busy[rd] at the same edge regWrite rises. Set and clear of same rd in one edge: set wins. ALU writes never touch busy.
- ld_issue to rd with busy[rd]=1 (and no same-edge clear): busy stays 1, issue_err set, held until reset.
- Continuous alu_valid starves the FIFO; once full ld_ready=0 and memory must hold the response.

## Timing
- Reset (async, immediate): writeReg=0, writeData=0, regWrite=0, busy=0, issue_err=0, FIFO empty, ld_ready=1.
- All outputs except ld_ready are registered.
- ALU latency: alu_valid sampled at edge N -> regWrite=1 with result in cycle after N (1 cycle).
- Load latency (uncontended): pushed at edge N, popped/emitted at edge N+1 -> regWrite in cycle after N+1 (2 cycles). Each ALU-occupied cycle adds one.
- regWrite is a one-cycle pulse per write; back-to-back writes allowed every cycle.
- FIFO pointers wrap modulo LD_FIFO_DEPTH; entries pop in push order.
- Reset mid-operation discards buffered responses and clears busy; no write emitted after reset until new input.

## Test plan
- Reset: assert reset_n=0 mid-cycle -> outputs zero immediately, ld_ready=1, busy=0.
- ALU path: alu_valid, rd=5, data=0xDEADBEEF -> next cycle regWrite=1, writeReg=5, writeData=0xDEADBEEF; rd=0 -> regWrite=0.
- Extension: ld_data=0x80FF7F01: LB addr 3 -> 0xFFFFFF80; LBU addr 1 -> 0x0000007F; LH addr 2 -> 0xFFFF80FF; LHU addr 0 -> 0x00007F01; LW -> 0x80FF7F01; each written 2 cycles after accept.
- Contention: alu_valid held 4 cycles while 3 loads arrive (depth 2) -> ld_ready=0 after 2 pushes, 3rd held; after alu_valid drops loads emerge in order, one per cycle, no loss.
- Scoreboard: ld_issue rd=7 -> busy[7]=1; response rd=7 -> busy[7] clears with its regWrite; same-edge re-issue rd=7 keeps busy[7]=1; issue to busy rd=9 -> issue_err=1 sticky.
- Random: constrained ALU/load mix vs. reference model of write order, values, busy, ld_ready over 10k cycles.
